// File: rtl/scb_pkg.sv
// scb_table shared package: default widths, entry bundle type and
// a lowest-set-bit helper used by the insert and write-back encoders.
package scb_pkg;

  localparam int NUM_CELLS_D = 8;
  localparam int W_PIP_D     = 2;
  localparam int W_PA_RX_D   = 5;
  localparam int W_STATE_D   = 7;
  localparam int LSB_W       = 64;

  typedef struct packed {
    logic                 inused;
    logic [W_PIP_D-1:0]   pip;
    logic [W_PA_RX_D-1:0] rd;
    logic [W_STATE_D-1:0] state;
  } scb_entry_t;

  function automatic int lsb_idx(input logic [LSB_W-1:0] v);
    lsb_idx = 0;
    for (int i = LSB_W - 1; i >= 0; i--) begin
      if (v[i]) lsb_idx = i;
    end
  endfunction

endpackage

// File: rtl/scb_entry.sv
// scb_table entry: in-use flag plus pip/rd/countdown fields.
// Flush wins over load; load wins over write-back free.
module scb_entry
  import scb_pkg::*;
#(
  parameter int W_PIP   = W_PIP_D,
  parameter int W_PA_RX = W_PA_RX_D,
  parameter int W_STATE = W_STATE_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               free,
  input  logic               flush,
  input  logic [W_PIP-1:0]   ld_pip,
  input  logic [W_PA_RX-1:0] ld_rd,
  input  logic [W_STATE-1:0] ld_lat,
  output logic               inused,
  output logic [W_PIP-1:0]   pip,
  output logic [W_PA_RX-1:0] rd,
  output logic [W_STATE-1:0] state
);

  // occupancy flag, the only field that is reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     inused <= 1'b0;
    else if (flush) inused <= 1'b0;
    else if (load)  inused <= 1'b1;
    else if (free)  inused <= 1'b0;
  end

  // payload load and countdown; holds at zero until freed
  always_ff @(posedge clk) begin
    if (load) begin
      pip   <= ld_pip;
      rd    <= ld_rd;
      state <= ld_lat;
    end else if (inused && state != '0) begin
      state <= state - 1'b1;
    end
  end

endmodule

// File: rtl/scb_table.sv
// scb_table: N-entry issue scoreboard with write-back arbitration,
// RAW and write-back hazard detection. Optional: SCB_OCC_CNT_EN.
module scb_table
  import scb_pkg::*;
#(
  parameter int NUM_CELLS = NUM_CELLS_D,
  parameter int W_PIP     = W_PIP_D,
  parameter int W_PA_RX   = W_PA_RX_D,
  parameter int W_STATE   = W_STATE_D,
  parameter int W_IDX     = $clog2(NUM_CELLS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_ins_valid,
  output logic               o_ins_ready,
  input  logic [W_PIP-1:0]   i_ins_pip,
  input  logic [W_PA_RX-1:0] i_ins_rd,
  input  logic [W_STATE-1:0] i_ins_lat,
  output logic [W_IDX-1:0]   o_ins_idx,
  output logic               o_wb_valid,
  input  logic               i_wb_ready,
  output logic [W_PIP-1:0]   o_wb_pip,
  output logic [W_PA_RX-1:0] o_wb_rd,
  output logic [W_IDX-1:0]   o_wb_idx,
  input  logic [W_PA_RX-1:0] i_rs0,
  input  logic [W_PA_RX-1:0] i_rs1,
  output logic               o_raw0,
  output logic               o_raw1,
  output logic               o_full,
`ifdef SCB_OCC_CNT_EN
  output logic [W_IDX:0]     o_occ,
`endif
  output logic               o_hz_wb
);

  logic [NUM_CELLS-1:0] used;
  logic [NUM_CELLS-1:0] cand;
  logic [NUM_CELLS-1:0] load;
  logic [NUM_CELLS-1:0] free;
  logic [NUM_CELLS-1:0] hz_hit;
  logic [NUM_CELLS-1:0] raw0_hit;
  logic [NUM_CELLS-1:0] raw1_hit;

  logic [W_PIP-1:0]   pip   [NUM_CELLS];
  logic [W_PA_RX-1:0] rd    [NUM_CELLS];
  logic [W_STATE-1:0] state [NUM_CELLS];

  logic ins_acc;
  logic wb_acc;

  for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
    scb_entry #(
      .W_PIP   (W_PIP),
      .W_PA_RX (W_PA_RX),
      .W_STATE (W_STATE)
    ) u_entry (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load[g]),
      .free   (free[g]),
      .flush  (i_flush),
      .ld_pip (i_ins_pip),
      .ld_rd  (i_ins_rd),
      .ld_lat (i_ins_lat),
      .inused (used[g]),
      .pip    (pip[g]),
      .rd     (rd[g]),
      .state  (state[g])
    );

    assign cand[g]     = used[g] & (state[g] == '0);
    assign hz_hit[g]   = used[g] & (state[g] == i_ins_lat);
    assign raw0_hit[g] = used[g] & (rd[g] == i_rs0);
    assign raw1_hit[g] = used[g] & (rd[g] == i_rs1);
    assign load[g]     = ins_acc & (o_ins_idx == W_IDX'(g));
    assign free[g]     = wb_acc & (o_wb_idx == W_IDX'(g));
  end

  assign o_ins_idx   = W_IDX'(lsb_idx(LSB_W'(~used)));
  assign o_full      = &used;
  assign o_hz_wb     = |hz_hit;
  assign o_ins_ready = i_ins_valid & ~o_full & ~o_hz_wb & ~i_flush;
  assign ins_acc     = o_ins_ready;

  assign o_wb_idx    = W_IDX'(lsb_idx(LSB_W'(cand)));
  assign o_wb_valid  = |cand;
  assign o_wb_pip    = o_wb_valid ? pip[o_wb_idx] : '0;
  assign o_wb_rd     = o_wb_valid ? rd[o_wb_idx] : '0;
  assign wb_acc      = o_wb_valid & i_wb_ready;

  assign o_raw0 = (i_rs0 != '0) & (|raw0_hit);
  assign o_raw1 = (i_rs1 != '0) & (|raw1_hit);

`ifdef SCB_OCC_CNT_EN
  localparam int W_OCC = W_IDX + 1;

  // occupancy counter tracking accepted inserts and freed entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       o_occ <= '0;
    else if (i_flush) o_occ <= '0;
    else              o_occ <= o_occ + W_OCC'(ins_acc) - W_OCC'(wb_acc);
  end

  a_occ : assert property (@(posedge clk) disable iff (!rst_n)
    int'(o_occ) == $countones(used));
`endif

endmodule

// File: tb/tb_scb_table.sv
// Directed testbench for scb_table.
// Hand-computed expectations, one checking task.
module tb_scb_table;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_flush;
  logic       i_ins_valid;
  logic       o_ins_ready;
  logic [1:0] i_ins_pip;
  logic [4:0] i_ins_rd;
  logic [6:0] i_ins_lat;
  logic [2:0] o_ins_idx;
  logic       o_wb_valid;
  logic       i_wb_ready;
  logic [1:0] o_wb_pip;
  logic [4:0] o_wb_rd;
  logic [2:0] o_wb_idx;
  logic [4:0] i_rs0;
  logic [4:0] i_rs1;
  logic       o_raw0;
  logic       o_raw1;
  logic       o_full;
  logic       o_hz_wb;
`ifdef SCB_OCC_CNT_EN
  logic [3:0] o_occ;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic seen;

  always #5 clk = ~clk;

  scb_table dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (i_flush),
    .i_ins_valid (i_ins_valid),
    .o_ins_ready (o_ins_ready),
    .i_ins_pip   (i_ins_pip),
    .i_ins_rd    (i_ins_rd),
    .i_ins_lat   (i_ins_lat),
    .o_ins_idx   (o_ins_idx),
    .o_wb_valid  (o_wb_valid),
    .i_wb_ready  (i_wb_ready),
    .o_wb_pip    (o_wb_pip),
    .o_wb_rd     (o_wb_rd),
    .o_wb_idx    (o_wb_idx),
    .i_rs0       (i_rs0),
    .i_rs1       (i_rs1),
    .o_raw0      (o_raw0),
    .o_raw1      (o_raw1),
    .o_full      (o_full),
`ifdef SCB_OCC_CNT_EN
    .o_occ       (o_occ),
`endif
    .o_hz_wb     (o_hz_wb)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ins(input int pip, input int rd, input int lat);
    i_ins_valid = 1'b1;
    i_ins_pip   = 2'(pip);
    i_ins_rd    = 5'(rd);
    i_ins_lat   = 7'(lat);
  endtask

  task automatic drain(input int n);
    i_wb_ready = 1'b1;
    repeat (n) tick();
    i_wb_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    i_flush     = 1'b0;
    i_ins_valid = 1'b1;
    i_ins_pip   = '0;
    i_ins_rd    = '0;
    i_ins_lat   = '0;
    i_wb_ready  = 1'b0;
    i_rs0       = '0;
    i_rs1       = '0;
    #3;
    chk("rst_wb_valid", o_wb_valid, 0);
    chk("rst_full", o_full, 0);
    chk("rst_raw0", o_raw0, 0);
    chk("rst_hz", o_hz_wb, 0);
    chk("rst_ready", o_ins_ready, 1);
    chk("rst_idx", o_ins_idx, 0);
    chk("rst_wb_rd", o_wb_rd, 0);
    i_ins_valid = 1'b0;
    #9;
    rst_n = 1'b1;
    tick();

    // single op, lat=3: candidate four cycles after insert
    ins(1, 7, 3);
    #1;
    chk("t1_ready", o_ins_ready, 1);
    chk("t1_idx", o_ins_idx, 0);
    tick();
    i_ins_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      #1;
      chk("t1_nowb", o_wb_valid, 0);
      tick();
    end
    #1;
    chk("t1_wb_valid", o_wb_valid, 1);
    chk("t1_wb_rd", o_wb_rd, 7);
    chk("t1_wb_pip", o_wb_pip, 1);
    chk("t1_wb_idx", o_wb_idx, 0);
    i_wb_ready = 1'b1;
    tick();
    #1;
    chk("t1_freed", o_wb_valid, 0);
    chk("t1_idx_free", o_ins_idx, 0);
    i_wb_ready = 1'b0;

    // write-back hazard on equal countdown
    ins(2, 3, 5);
    #1;
    chk("t2_ready0", o_ins_ready, 1);
    tick();
    i_ins_lat = 7'd5;
    i_ins_rd  = 5'd4;
    #1;
    chk("t2_hz", o_hz_wb, 1);
    chk("t2_hz_ready", o_ins_ready, 0);
    i_ins_lat = 7'd3;
    #1;
    chk("t2_nohz", o_hz_wb, 0);
    chk("t2_ready1", o_ins_ready, 1);
    chk("t2_idx1", o_ins_idx, 1);
    tick();
    i_ins_valid = 1'b0;
    i_ins_lat   = 7'd4;
    #1;
    chk("t2_hz_state4", o_hz_wb, 1);
    i_wb_ready = 1'b1;
    repeat (3) tick();
    #1;
    chk("t2_wb_first", o_wb_idx, 1);
    chk("t2_wb_first_rd", o_wb_rd, 4);
    tick();
    #1;
    chk("t2_wb_second", o_wb_idx, 0);
    chk("t2_wb_second_v", o_wb_valid, 1);
    tick();
    #1;
    chk("t2_empty", o_wb_valid, 0);
    i_wb_ready = 1'b0;

    // fill all entries, stall, then drain in index order
    for (int i = 0; i < 8; i++) begin
      ins(i, 16 + i, 10 + i);
      #1;
      chk("t3_fill_ready", o_ins_ready, 1);
      chk("t3_fill_idx", o_ins_idx, i);
      tick();
    end
    ins(0, 1, 50);
    #1;
    chk("t3_full", o_full, 1);
    chk("t3_full_ready", o_ins_ready, 0);
`ifdef SCB_OCC_CNT_EN
    chk("t3_occ", o_occ, 8);
`endif
    i_ins_valid = 1'b0;
    repeat (20) tick();
    i_ins_lat = 7'd0;
    #1;
    chk("t3_wb_valid", o_wb_valid, 1);
    chk("t3_hz_lat0", o_hz_wb, 1);
    ins(3, 30, 20);
    i_wb_ready = 1'b1;
    #1;
    chk("t3_full_wb_ready", o_ins_ready, 0);
    chk("t3_wb_idx0", o_wb_idx, 0);
    chk("t3_wb_rd0", o_wb_rd, 16);
    tick();
    #1;
    chk("t3_reuse_ready", o_ins_ready, 1);
    chk("t3_reuse_idx", o_ins_idx, 0);
    chk("t3_wb_idx1", o_wb_idx, 1);
    tick();
    i_ins_valid = 1'b0;
    for (int i = 2; i < 8; i++) begin
      #1;
      chk("t3_wb_idx", o_wb_idx, i);
      chk("t3_wb_rd", o_wb_rd, 16 + i);
      tick();
    end
    #1;
    chk("t3_after_valid", o_wb_valid, 0);
    chk("t3_after_full", o_full, 0);
    chk("t3_after_idx", o_ins_idx, 1);
    drain(20);

    // RAW detection, no bypass during write-back
    ins(0, 12, 2);
    #1;
    chk("t4_ready", o_ins_ready, 1);
    tick();
    i_ins_valid = 1'b0;
    i_rs0 = 5'd12;
    i_rs1 = 5'd0;
    #1;
    chk("t4_raw0", o_raw0, 1);
    chk("t4_raw1_zero", o_raw1, 0);
    i_rs1 = 5'd12;
    #1;
    chk("t4_raw1", o_raw1, 1);
    i_rs1 = 5'd13;
    #1;
    chk("t4_raw1_miss", o_raw1, 0);
    i_wb_ready = 1'b1;
    tick();
    tick();
    #1;
    chk("t4_wb_valid", o_wb_valid, 1);
    chk("t4_raw_wb", o_raw0, 1);
    tick();
    #1;
    chk("t4_raw_gone", o_raw0, 0);
    i_wb_ready = 1'b0;
    i_rs0 = '0;
    i_rs1 = '0;

    // flush with pending entries and a concurrent insert
    for (int i = 0; i < 3; i++) begin
      ins(0, i + 1, 6 + 2 * i);
      tick();
    end
    ins(1, 5, 1);
    i_flush = 1'b1;
    #1;
    chk("t5_flush_ready", o_ins_ready, 0);
    tick();
    i_flush     = 1'b0;
    i_ins_valid = 1'b0;
    #1;
    chk("t5_full", o_full, 0);
    chk("t5_idx", o_ins_idx, 0);
`ifdef SCB_OCC_CNT_EN
    chk("t5_occ", o_occ, 0);
`endif
    seen = 1'b0;
    repeat (15) begin
      if (o_wb_valid) seen = 1'b1;
      tick();
    end
    chk("t5_no_wb", seen, 0);

    // asynchronous reset mid-countdown
    ins(0, 9, 5);
    tick();
    ins(0, 10, 20);
    tick();
    i_ins_valid = 1'b0;
    i_rs0 = 5'd9;
    i_rs1 = 5'd10;
    #1;
    chk("t6_raw0_pre", o_raw0, 1);
    chk("t6_raw1_pre", o_raw1, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_raw0_rst", o_raw0, 0);
    chk("t6_raw1_rst", o_raw1, 0);
    #3;
    rst_n = 1'b1;
    i_rs0 = '0;
    i_rs1 = '0;
    tick();
    ins(2, 11, 4);
    #1;
    chk("t6_ready", o_ins_ready, 1);
    chk("t6_idx", o_ins_idx, 0);
    tick();
    i_ins_valid = 1'b0;
    #1;
    chk("t6_next_idx", o_ins_idx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
